// File: rtl/classify_ctrl.sv
// classify_ctrl: sequences the LeNet-5 argmax comparator handshake and encodes its
// one-hot class vector into a binary digit with tie/none flags on a valid/ready port.
module classify_ctrl #(
  parameter int CLASS_NUM   = 10,
  parameter int DIGIT_WIDTH = 4,
  parameter int TIMEOUT     = 64,
  parameter int TO_WIDTH    = 7,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fc_finish,
  output logic                   fc_read,
  output logic                   cmp_pre_finish,
  input  logic                   cmp_i_read,
  input  logic                   cmp_finish,
  output logic                   cmp_later_read,
  input  logic [0:CLASS_NUM-1]   cmp_out_num,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DIGIT_WIDTH-1:0] res_digit,
  output logic                   res_tie,
  output logic                   res_none,
  output logic [FRAME_WIDTH-1:0] frame_cnt,
  output logic                   timeout_err,
  input  logic                   err_clr,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    CAPTURE   = 3'd3,
    RELEASE   = 3'd4,
    DRAIN     = 3'd5,
    ABORT     = 3'd6
  } state_t;

  localparam logic [TO_WIDTH-1:0]    WDOG_LAST = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [DIGIT_WIDTH-1:0] NO_CLASS  = {DIGIT_WIDTH{1'b1}};

  state_t                state_r;
  logic [TO_WIDTH-1:0]   wdog_r;
  logic [0:CLASS_NUM-1]  vec_r;

  // Lowest set class index; all-ones when no class bit is set.
  function automatic logic [DIGIT_WIDTH-1:0] lowest_idx(input logic [0:CLASS_NUM-1] v);
    logic [DIGIT_WIDTH-1:0] d;
    d = NO_CLASS;
    for (int i = CLASS_NUM - 1; i >= 0; i--) begin
      if (v[i]) begin
        d = DIGIT_WIDTH'(i);
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // Clearing one set bit leaves something only when two or more bits were set.
  function automatic logic multi_hot(input logic [0:CLASS_NUM-1] v);
    return |(v & (v - CLASS_NUM'(1)));
  endfunction

  // Control FSM with watchdog, result register and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      wdog_r         <= '0;
      vec_r          <= '0;
      fc_read        <= 1'b0;
      cmp_pre_finish <= 1'b0;
      cmp_later_read <= 1'b0;
      res_valid      <= 1'b0;
      res_digit      <= NO_CLASS;
      res_tie        <= 1'b0;
      res_none       <= 1'b0;
      frame_cnt      <= '0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      fc_read        <= 1'b0;
      cmp_later_read <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
        frame_cnt <= frame_cnt + FRAME_WIDTH'(1);
      end
      case (state_r)
        IDLE: begin
          if (fc_finish && (!res_valid || res_ready)) begin
            state_r        <= START;
            cmp_pre_finish <= 1'b1;
            wdog_r         <= '0;
            busy           <= 1'b1;
          end
        end
        START, WAIT_DONE: begin
          wdog_r <= wdog_r + TO_WIDTH'(1);
          // The watchdog overrides any handshake seen in its final cycle; set beats err_clr.
          if (wdog_r == WDOG_LAST) begin
            state_r        <= ABORT;
            cmp_pre_finish <= 1'b0;
            cmp_later_read <= 1'b1;
            timeout_err    <= 1'b1;
          end else if (state_r == START && cmp_i_read) begin
            state_r        <= WAIT_DONE;
            cmp_pre_finish <= 1'b0;
            fc_read        <= 1'b1;
          end else if (state_r == WAIT_DONE && cmp_finish) begin
            state_r <= CAPTURE;
            vec_r   <= cmp_out_num;
          end
        end
        CAPTURE: begin
          res_digit      <= lowest_idx(vec_r);
          res_tie        <= multi_hot(vec_r);
          res_none       <= ~(|vec_r);
          res_valid      <= 1'b1;
          cmp_later_read <= 1'b1;
          state_r        <= RELEASE;
        end
        RELEASE, ABORT: begin
          state_r <= DRAIN;
        end
        DRAIN: begin
          if (!cmp_finish) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r        <= IDLE;
          cmp_pre_finish <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_classify_ctrl.sv
// tb_classify_ctrl: directed bench with a behavioural comparator and a result scoreboard.
module tb_classify_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fc_finish;
  logic        fc_read;
  logic        cmp_pre_finish;
  logic        cmp_i_read;
  logic        cmp_finish;
  logic        cmp_later_read;
  logic [0:9]  cmp_out_num;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_digit;
  logic        res_tie;
  logic        res_none;
  logic [15:0] frame_cnt;
  logic        timeout_err;
  logic        err_clr;
  logic        busy;

  classify_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fc_finish(fc_finish), .fc_read(fc_read),
    .cmp_pre_finish(cmp_pre_finish), .cmp_i_read(cmp_i_read), .cmp_finish(cmp_finish),
    .cmp_later_read(cmp_later_read), .cmp_out_num(cmp_out_num), .res_valid(res_valid),
    .res_ready(res_ready), .res_digit(res_digit), .res_tie(res_tie), .res_none(res_none),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err), .err_clr(err_clr), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] digit;
    logic       tie;
    logic       none;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [0:9] mdl_vec = '0;
  int         mdl_lat = 12;
  bit         mdl_never = 1'b0;
  int         m_st;
  int         m_cnt;
  int         n_fc_read = 0;
  int         n_later = 0;
  int         n_valid = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/level counters sampled away from the active edge.
  always @(negedge clk) begin
    n_fc_read += int'(fc_read);
    n_later   += int'(cmp_later_read);
    n_valid   += int'(res_valid);
  end

  // Comparator model: ack on pre_finish, finish after mdl_lat, drop finish 2 cycles after later_read.
  initial begin
    cmp_i_read = 1'b0; cmp_finish = 1'b0; cmp_out_num = '0; m_st = 0; m_cnt = 0;
    forever begin
      @(posedge clk); #1;
      cmp_i_read = 1'b0;
      if (!rst_n) begin
        cmp_finish = 1'b0; cmp_out_num = '0; m_st = 0; m_cnt = 0;
      end else if (m_st != 0 && cmp_later_read) begin
        m_st = 3; m_cnt = 0;
      end else begin
        case (m_st)
          0: if (cmp_pre_finish) begin cmp_i_read = 1'b1; m_st = 1; m_cnt = 0; end
          1: begin
            m_cnt++;
            if (!mdl_never && m_cnt >= mdl_lat) begin
              cmp_finish = 1'b1; cmp_out_num = mdl_vec; m_st = 2;
            end
          end
          3: begin
            m_cnt++;
            if (m_cnt >= 2) begin cmp_finish = 1'b0; m_st = 0; end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [0:9] vec, input int lat, input string tag);
    int n;
    mdl_vec = vec; mdl_lat = lat; fc_finish = 1'b1;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_start"}, 32'(busy), 32'd1);
    fc_finish = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_digit"}, 32'(res_digit), 32'(e.digit));
      chk({tag, "_tie"}, 32'(res_tie), 32'(e.tie));
      chk({tag, "_none"}, 32'(res_none), 32'(e.none));
    end
  endtask

  initial begin
    int c0, c1, c2, n, busy_seen, valid_seen;
    rst_n = 1'b0; fc_finish = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digit", 32'(res_digit), 32'hF);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_pre", 32'(cmp_pre_finish), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single class, result accepted immediately.
    res_ready = 1'b1;
    c0 = n_fc_read; c1 = n_later; c2 = n_valid;
    sb_q.push_back('{digit: 4'd6, tie: 1'b0, none: 1'b0});
    start_frame(10'b0000001000, 12, "t1");
    wait_valid("t1");
    check_result("t1");
    wait_idle("t1");
    chk("t1_frame", 32'(frame_cnt), 32'd1);
    chk("t1_fc_read_pulses", 32'(n_fc_read - c0), 32'd1);
    chk("t1_later_pulses", 32'(n_later - c1), 32'd1);
    chk("t1_valid_cycles", 32'(n_valid - c2), 32'd1);

    // Tie and empty vectors.
    sb_q.push_back('{digit: 4'd1, tie: 1'b1, none: 1'b0});
    start_frame(10'b0100100000, 7, "t2");
    wait_valid("t2");
    check_result("t2");
    wait_idle("t2");
    sb_q.push_back('{digit: 4'hF, tie: 1'b0, none: 1'b1});
    start_frame(10'b0000000000, 4, "t3");
    wait_valid("t3");
    check_result("t3");
    wait_idle("t3");
    chk("t3_frame", 32'(frame_cnt), 32'd3);

    // Backpressure: held result blocks a new start.
    res_ready = 1'b0;
    sb_q.push_back('{digit: 4'd2, tie: 1'b0, none: 1'b0});
    start_frame(10'b0010000000, 6, "t4a");
    wait_valid("t4a");
    wait_idle("t4a");
    mdl_vec = 10'b0000000100; mdl_lat = 5;
    fc_finish = 1'b1;
    busy_seen = 0; valid_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      busy_seen += int'(busy);
      valid_seen += int'(res_valid);
    end
    chk("t4_no_restart", 32'(busy_seen), 32'd0);
    chk("t4_valid_held", 32'(valid_seen), 32'd30);
    check_result("t4a");
    sb_q.push_back('{digit: 4'd7, tie: 1'b0, none: 1'b0});
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4b_start", 32'(busy), 32'd1);
    fc_finish = 1'b0;
    wait_valid("t4b");
    check_result("t4b");
    wait_idle("t4b");
    chk("t4_frame", 32'(frame_cnt), 32'd5);

    // Watchdog abort, sticky error, clear, then a normal frame.
    mdl_never = 1'b1;
    c1 = n_later; c2 = n_valid;
    start_frame(10'b1000000000, 1, "t5");
    n = 0;
    while (!cmp_later_read && n < 200) begin @(negedge clk); n++; end
    chk("t5_abort_cycle", 32'(n), 32'd64);
    chk("t5_timeout_err", 32'(timeout_err), 32'd1);
    wait_idle("t5");
    repeat (3) @(negedge clk);
    chk("t5_sticky", 32'(timeout_err), 32'd1);
    chk("t5_later_pulses", 32'(n_later - c1), 32'd1);
    chk("t5_no_valid", 32'(n_valid - c2), 32'd0);
    chk("t5_frame", 32'(frame_cnt), 32'd5);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_err_clr", 32'(timeout_err), 32'd0);
    mdl_never = 1'b0;
    sb_q.push_back('{digit: 4'd3, tie: 1'b0, none: 1'b0});
    start_frame(10'b0001000000, 9, "t5n");
    wait_valid("t5n");
    check_result("t5n");
    wait_idle("t5n");
    chk("t5n_frame", 32'(frame_cnt), 32'd6);

    // Reset during WAIT_DONE.
    start_frame(10'b0000000001, 40, "t6");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_digit", 32'(res_digit), 32'hF);
    chk("t6_frame", 32'(frame_cnt), 32'd0);
    chk("t6_valid", 32'(res_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_q.push_back('{digit: 4'd9, tie: 1'b0, none: 1'b0});
    start_frame(10'b0000000001, 8, "t6n");
    wait_valid("t6n");
    check_result("t6n");
    wait_idle("t6n");
    chk("t6n_frame", 32'(frame_cnt), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/classify_ctrl.md
Name: classify_ctrl

Overview:
- Sequences the final argmax stage of the LeNet-5 pipeline.
- Takes the FC-layer "scores ready" indication and drives the 10-way comparator's pre_finish/i_read/finish/later_read handshake.
- Captures the comparator's one-hot class vector and encodes it into a binary digit with tie/none flags.
- Presents the result on a valid/ready port, with a frame counter and a watchdog timeout.

Parameters:
- CLASS_NUM, 10, number of classes (width of the one-hot vector).
- DIGIT_WIDTH, 4, width of the encoded digit.
- TIMEOUT, 64, maximum cycles allowed in START plus WAIT_DONE before abort.
- TO_WIDTH, 7, width of the watchdog counter (must hold TIMEOUT).
- FRAME_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fc_finish  in  1  level; FC scores are valid on the comparator data input.
- fc_read  out  1  1-cycle pulse; the comparator has latched the scores, so FC may release them.
- cmp_pre_finish  out  1  start request to the comparator.
- cmp_i_read  in  1  comparator latch acknowledge (pulse).
- cmp_finish  in  1  comparator done (level, held until released).
- cmp_later_read  out  1  1-cycle release pulse to the comparator.
- cmp_out_num  in  [0:CLASS_NUM-1]  one-hot result; bit 0 is class 0.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_digit  out  DIGIT_WIDTH  encoded class; 4'hF when there is no class.
- res_tie  out  1  more than one bit of cmp_out_num was set.
- res_none  out  1  no bit of cmp_out_num was set.
- frame_cnt  out  FRAME_WIDTH  count of accepted results; wraps.
- timeout_err  out  1  sticky watchdog error.
- err_clr  in  1  clears timeout_err.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state IDLE. All outputs are 0 except res_digit, which resets to 4'hF. The watchdog counter and the captured vector are cleared.
- All outputs are registered.
- States: IDLE, START, WAIT_DONE, CAPTURE, RELEASE, DRAIN, ABORT.
- IDLE -> START when fc_finish=1 and the result slot is free. The slot is free when res_valid=0, or res_valid=1 and res_ready=1 in the same cycle.
- If fc_finish=1 while the slot is held, stay in IDLE; do not start.
- START:
  - cmp_pre_finish=1 throughout START.
  - On cmp_i_read=1: go to WAIT_DONE and pulse fc_read for 1 cycle on the next cycle.
  - cmp_pre_finish drops on the same edge that leaves START.
- WAIT_DONE -> CAPTURE on cmp_finish=1. cmp_out_num is registered on that edge.
- CAPTURE (1 cycle):
  - Encode res_digit = lowest set index.
  - res_tie = popcount > 1.
  - res_none = popcount == 0; in that case res_digit = 4'hF.
  - Set res_valid=1 on the exit edge. Go to RELEASE.
- RELEASE (1 cycle): cmp_later_read=1. Go to DRAIN.
- DRAIN: wait for cmp_finish=0 (the comparator returns to idle about 2 cycles after later_read), then go to IDLE.
  - This guarantees no restart while the comparator's finish flag is still high.
- Result handshake:
  - res_valid stays high until the first cycle with res_ready=1; it clears on that edge.
  - frame_cnt increments by 1 on each valid&&ready, wrapping at 2^FRAME_WIDTH.
  - res_digit/res_tie/res_none hold their values until the next CAPTURE.
- Watchdog:
  - Counter clears on entry to START and counts every cycle in START and WAIT_DONE.
  - When the count reaches TIMEOUT-1: go to ABORT and set timeout_err=1.
- ABORT (1 cycle):
  - cmp_pre_finish=0, cmp_later_read=1 (releases the comparator if it was mid-complete).
  - No result is produced and frame_cnt does not change. Then go to DRAIN.
- timeout_err is sticky.
  - err_clr=1 clears it on the next edge.
  - If err_clr and a new timeout fire in the same cycle, set wins.
- A cmp_finish seen in IDLE or START is ignored; no capture happens.
- Reset asserted mid-operation returns immediately to the reset values. The comparator is reset by the same rst_n.

Test Plan:
1. Comparator model returns cmp_out_num=10'b0000001000 (bit 6) after 12 cycles; res_ready=1 -> res_digit=6, tie=0, none=0; res_valid high exactly 1 cycle; frame_cnt=1; fc_read and cmp_later_read pulse once each.
2. cmp_out_num=10'b0100100000 (bits 1 and 4) -> res_digit=1, res_tie=1.
3. cmp_out_num=0 -> res_digit=4'hF, res_none=1.
4. res_ready=0 for 30 cycles with fc_finish held high -> no second START and res_valid held. Then res_ready=1 -> second frame starts; frame_cnt=2 after both results are accepted.
5. Comparator never asserts cmp_finish -> at cycle TIMEOUT=64 after START: ABORT, cmp_later_read pulses, timeout_err=1, no res_valid. Then err_clr -> timeout_err=0, and the next frame completes normally.
6. rst_n low during WAIT_DONE -> all outputs at reset values the same cycle, busy=0. After release, a normal frame (class 9) gives res_digit=9 and frame_cnt=1.
